// File: rtl/twodemux_pkg.sv
// twodemux_pkg: shared constants and slot state for the 1-to-2 stream demux.
// TWODEMUX_CNT_EN enables per-channel delivery counters.
package twodemux_pkg;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_e;

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry valid/ready output register for one demux channel.
// TWODEMUX_CNT_EN adds a saturating delivered-word counter.
module demux_slot
  import twodemux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
`ifdef TWODEMUX_CNT_EN
  ,
  parameter int CNT_W = DEF_CNT_W
`endif
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_can_load
`ifdef TWODEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] o_cnt
`endif
);

  slot_e            r_state;
  slot_e            w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic             w_drain;

  assign w_drain    = (r_state == FULL) && i_ready;
  assign o_can_load = (r_state == EMPTY) || i_ready;
  assign o_valid    = (r_state == FULL);
  assign o_data     = r_data;

  // A load wins over a drain: the new word replaces the departing one.
  always_comb begin
    w_state_nxt = r_state;
    if (i_load) begin
      w_state_nxt = FULL;
    end else if (w_drain) begin
      w_state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end
  end

`ifdef TWODEMUX_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (w_drain && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
`endif

endmodule

// File: rtl/twodemux_stream.sv
// twodemux_stream: registered 1-to-2 valid/ready demux, one slot per channel.
// TWODEMUX_CNT_EN adds cnt_a/cnt_b delivery counters.
module twodemux_stream
  import twodemux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
`ifdef TWODEMUX_CNT_EN
  ,
  parameter int CNT_W = DEF_CNT_W
`endif
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  input  logic             din_sel,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] douta,
  output logic             douta_valid,
  input  logic             douta_ready,
  output logic [WIDTH-1:0] doutb,
  output logic             doutb_valid,
  input  logic             doutb_ready
`ifdef TWODEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
`endif
);

  logic w_a_can;
  logic w_b_can;
  logic w_fire;
  logic w_load_a;
  logic w_load_b;

  // Readiness follows only the addressed channel, so a stall stays local.
  assign din_ready = (din_sel == SEL_B) ? w_b_can : w_a_can;
  assign w_fire    = din_valid && din_ready;
  assign w_load_a  = w_fire && (din_sel == SEL_A);
  assign w_load_b  = w_fire && (din_sel == SEL_B);

  demux_slot #(
    .WIDTH (WIDTH)
`ifdef TWODEMUX_CNT_EN
    ,
    .CNT_W (CNT_W)
`endif
  ) u_slot_a (
    .clk        (clk),
    .rstn       (rstn),
    .i_load     (w_load_a),
    .i_data     (din),
    .i_ready    (douta_ready),
    .o_data     (douta),
    .o_valid    (douta_valid),
    .o_can_load (w_a_can)
`ifdef TWODEMUX_CNT_EN
    ,
    .o_cnt      (cnt_a)
`endif
  );

  demux_slot #(
    .WIDTH (WIDTH)
`ifdef TWODEMUX_CNT_EN
    ,
    .CNT_W (CNT_W)
`endif
  ) u_slot_b (
    .clk        (clk),
    .rstn       (rstn),
    .i_load     (w_load_b),
    .i_data     (din),
    .i_ready    (doutb_ready),
    .o_data     (doutb),
    .o_valid    (doutb_valid),
    .o_can_load (w_b_can)
`ifdef TWODEMUX_CNT_EN
    ,
    .o_cnt      (cnt_b)
`endif
  );

endmodule

// File: tb/tb_twodemux_stream.sv
// tb_twodemux_stream: scoreboard bench for the 1-to-2 stream demux.
// Define TWODEMUX_CNT_EN to also check the delivery counters (CNT_W=2).
module tb_twodemux_stream;
  import twodemux_pkg::*;

  localparam int W = 4;
`ifdef TWODEMUX_CNT_EN
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;
`endif

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_sel = 1'b0;
  logic         din_valid = 1'b0;
  logic         din_ready;
  logic [W-1:0] douta;
  logic         douta_valid;
  logic         douta_ready = 1'b0;
  logic [W-1:0] doutb;
  logic         doutb_valid;
  logic         doutb_ready = 1'b0;
`ifdef TWODEMUX_CNT_EN
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;
`endif

  always #5 clk = ~clk;

  twodemux_stream #(
    .WIDTH (W)
`ifdef TWODEMUX_CNT_EN
    ,
    .CNT_W (CW)
`endif
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .din         (din),
    .din_sel     (din_sel),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .douta       (douta),
    .douta_valid (douta_valid),
    .douta_ready (douta_ready),
    .doutb       (doutb),
    .doutb_valid (doutb_valid),
    .doutb_ready (doutb_ready)
`ifdef TWODEMUX_CNT_EN
    ,
    .cnt_a       (cnt_a),
    .cnt_b       (cnt_b)
`endif
  );

  // Reference: each channel is a FIFO of accepted, undelivered words.
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  int           exp_ca = 0;
  int           exp_cb = 0;
  int           n_tests = 0;
  int           n_fail = 0;
  bit           rnd_stop = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [W-1:0] d, input logic s);
    bit fire;
    fire      = 1'b0;
    din       = d;
    din_sel   = s;
    din_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      fire = din_ready;
      @(posedge clk);
      if (fire) break;
    end
    if (fire) begin
      if (s == SEL_B) qb.push_back(d);
      else qa.push_back(d);
    end else begin
      check("send_timeout", 0, 1);
    end
    #1;
    din_valid = 1'b0;
  endtask

  // Monitor: compare DUT outputs with the reference mid-cycle.
  always @(negedge clk) begin
    if (rstn) begin
      bit exp_rdy;
      check("a_valid", int'(douta_valid), int'(qa.size() != 0));
      check("b_valid", int'(doutb_valid), int'(qb.size() != 0));
      if (qa.size() != 0) check("a_data", int'(douta), int'(qa[0]));
      if (qb.size() != 0) check("b_data", int'(doutb), int'(qb[0]));
      if (din_sel == SEL_B) exp_rdy = (qb.size() == 0) || doutb_ready;
      else exp_rdy = (qa.size() == 0) || douta_ready;
      check("din_ready", int'(din_ready), int'(exp_rdy));
`ifdef TWODEMUX_CNT_EN
      check("cnt_a", int'(cnt_a), exp_ca);
      check("cnt_b", int'(cnt_b), exp_cb);
`endif
      if (douta_valid && douta_ready && qa.size() != 0) begin
        void'(qa.pop_front());
        if (exp_ca < (1 << 30)) exp_ca++;
      end
      if (doutb_valid && doutb_ready && qb.size() != 0) begin
        void'(qb.pop_front());
        if (exp_cb < (1 << 30)) exp_cb++;
      end
`ifdef TWODEMUX_CNT_EN
      if (exp_ca > CMAX) exp_ca = CMAX;
      if (exp_cb > CMAX) exp_cb = CMAX;
`endif
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    check("rst_a_valid", int'(douta_valid), 0);
    check("rst_b_valid", int'(doutb_valid), 0);
    check("rst_a_data", int'(douta), 0);
    check("rst_b_data", int'(doutb), 0);

    // Alternating route with both consumers ready.
    douta_ready = 1'b1;
    doutb_ready = 1'b1;
    send(4'ha, SEL_A);
    check("alt_a_valid", int'(douta_valid), 1);
    check("alt_a_data", int'(douta), 10);
    send(4'hb, SEL_B);
    check("alt_b_valid", int'(doutb_valid), 1);
    check("alt_b_data", int'(doutb), 11);
    check("alt_a_drained", int'(douta_valid), 0);

    // Stall A, second word must wait.
    douta_ready = 1'b0;
    send(4'h1, SEL_A);
    fork
      send(4'h2, SEL_A);
      begin
        repeat (3) @(posedge clk);
        #1;
        check("stall_ready", int'(din_ready), 0);
        check("stall_hold", int'(douta), 1);
        douta_ready = 1'b1;
      end
    join
    check("stall_next", int'(douta), 2);
    check("stall_next_v", int'(douta_valid), 1);

    // A full and stalled, B still flows.
    douta_ready = 1'b0;
    send(4'hb, SEL_B);
    check("indep_b", int'(doutb), 11);
    check("indep_a_hold", int'(douta), 2);
    check("indep_a_v", int'(douta_valid), 1);
    douta_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back fill and drain on B.
    for (int i = 3; i <= 5; i++) begin
      send(W'(i), SEL_B);
      check("strm_b_v", int'(doutb_valid), 1);
      check("strm_b", int'(doutb), i);
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a cycle while A holds a word.
    douta_ready = 1'b0;
    send(4'ha, SEL_A);
    #1;
    rstn = 1'b0;
    #1;
    check("mid_rst_a_v", int'(douta_valid), 0);
    check("mid_rst_a_d", int'(douta), 0);
    qa.delete();
    qb.delete();
    exp_ca = 0;
    exp_cb = 0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
    check("mid_rst_ready", int'(din_ready), 1);
    @(posedge clk);
    #1;

    // Five deliveries on A after reset.
    douta_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(W'(i + 6), SEL_A);
      @(posedge clk);
      #1;
`ifdef TWODEMUX_CNT_EN
      check("cnt_a_seq", int'(cnt_a), (i + 1 > CMAX) ? CMAX : i + 1);
      check("cnt_b_zero", int'(cnt_b), 0);
`endif
    end

    // Randomized traffic and back-pressure.
    fork
      begin
        while (!rnd_stop) begin
          @(posedge clk);
          #1;
          douta_ready = 1'($urandom_range(0, 1));
          doutb_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int n = 0; n < 300; n++) begin
          send(W'($urandom), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_stop = 1'b1;
      end
    join
    douta_ready = 1'b1;
    doutb_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("final_qa", qa.size(), 0);
    check("final_qb", qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
